instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
//  Fetch stage that consumes the next-sequential PC (PC+4) and turns it into instruction-memory reads.
//  Holds the PC register and issues one read per instruction over a valid/ready request channel.
//  Accepts the read response and presents {instr, pc, pc+4} to decode over a valid/ready handshake.
//  Handles redirects from execute (branch/jump) and discards stale in-flight responses.
// PARAMETERS
//  RESET_VECTOR  32'h0000_0000  PC value loaded on reset
//  NOP_INSTR     32'h0000_0013  if_instr value whenever if_valid=0 (addi x0,x0,0)
// PORTS
//  clk            in   1   single clock, rising edge
//  rst_n          in   1   asynchronous, active-low reset
//  redirect       in   1   execute requests PC change this cycle
//  redirect_pc    in   32  redirect target
//  imem_req_valid out  1   read request valid
//  imem_req_ready in   1   memory accepts request
//  imem_addr      out  32  read address (= PC)
//  imem_rsp_valid in   1   read data valid (exactly one per accepted request, >=1 cycle later)
//  imem_rdata     in   32  read data
//  if_valid       out  1   fetch packet valid to decode
//  if_ready       in   1   decode accepts packet
//  if_instr       out  32  fetched instruction
//  if_pc          out  32  PC of if_instr
//  if_pcplus4     out  32  if_pc + 4
//  if_fault       out  1   misaligned-target fault (see CONFIGURATION)
// BEHAVIOUR
//  Reset (rst_n low): state=BOOT, PC=RESET_VECTOR; imem_req_valid=0, if_valid=0, if_fault=0,
//   if_instr=NOP_INSTR, if_pc=RESET_VECTOR, if_pcplus4=RESET_VECTOR+4, imem_addr=RESET_VECTOR.
//  States: BOOT, REQ, WAIT, HOLD, DROP. One outstanding request max. imem_addr = PC always.
//  BOOT: unconditionally -> REQ next cycle (first request one cycle after reset release).
//  REQ : imem_req_valid = ~redirect. redirect: PC<=redirect_pc, stay REQ.
//        else req_ready: -> WAIT. else stay.
//  WAIT: redirect & rsp_valid: discard data, PC<=redirect_pc, -> REQ.
//        redirect only: PC<=redirect_pc, -> DROP.  rsp_valid only: latch rdata -> HOLD.
//  HOLD: if_valid = ~redirect; if_instr=latched data, if_pc=PC, if_pcplus4=PC+4.
//        redirect: packet dropped (no handshake), PC<=redirect_pc, -> REQ (redirect beats if_ready).
//        if_valid & if_ready: PC<=PC+4, -> REQ. else hold all outputs stable.
//  DROP: waits for the stale response; rsp_valid: discard -> REQ. redirect: PC<=redirect_pc, stay DROP
//        (also if same cycle as rsp_valid: -> REQ with new PC).
//  imem_rsp_valid in BOOT/REQ/HOLD is a protocol error: ignored.
//  Arithmetic: PC+4 modulo 2^32; 32'hFFFF_FFFC wraps to 32'h0000_0000.
//  Latency: 1-cycle memory, ready decode -> one packet per 3 cycles (REQ,WAIT,HOLD).
//  Reset mid-operation: immediate return to reset values; the subsequent response is the memory's
//   responsibility (memory shares rst_n).
// CONFIGURATION
//  FETCH_MISALIGN_CHECK_EN defined: redirect_pc[1:0]!=0 -> no request issued; PC<=redirect_pc, -> HOLD
//   with if_valid=1, if_fault=1, if_instr=NOP_INSTR; handshake leaves fault HOLD like a normal packet,
//   except a redirect while in fault HOLD replaces it. if_fault=0 for all normal packets.
//  Not defined: redirect_pc[1:0] forced to 2'b00 on load; if_fault tied 0.
// TESTING
//  Reset release, mem ready/1-cycle rsp, if_ready=1 -> addrs 0x0,0x4,0x8; packets pc/pcplus4 0/4, 4/8.
//  if_ready=0 for 5 cycles in HOLD -> if_valid, if_instr, if_pc stable; no new imem request.
//  redirect to 0x100 in WAIT, rsp 3 cycles later -> stale data never on if_*; next addr 0x100.
//  redirect 0x200 same cycle as rsp_valid in WAIT -> data discarded; next cycle req addr 0x200.
//  redirect to 0xFFFF_FFFC, accept packet -> if_pcplus4=0; next request address 0x0.
//  EN: redirect to 0x102 -> no request, if_fault=1, if_pc=0x102; off: next addr 0x100, if_fault=0.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - fetch stage: PC register, imem request/response, decode packet handshake
// Optional misaligned-redirect fault path enabled by FETCH_MISALIGN_CHECK_EN.
module instr_fetch_unit #(
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR    = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rdata,
   output logic        if_valid,
   input  logic        if_ready,
   output logic [31:0] if_instr,
   output logic [31:0] if_pc,
   output logic [31:0] if_pcplus4,
   output logic        if_fault
);

   typedef enum logic [2:0] {S_BOOT, S_REQ, S_WAIT, S_HOLD, S_DROP} state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] tgt_pc;
   logic        fault_q;
   logic        stale_q;
   logic        hold_stale;

`ifdef FETCH_MISALIGN_CHECK_EN
   logic fault_d, stale_d;
   logic misalign;

   assign tgt_pc   = redirect_pc;
   assign misalign = redirect & (redirect_pc[1:0] != 2'b00);
`else
   assign tgt_pc  = redirect_pc & 32'hFFFF_FFFC;
   assign fault_q = 1'b0;
   assign stale_q = 1'b0;
`endif

   // A fault HOLD entered with a request still in flight must drain it before fetching again.
   assign hold_stale = stale_q & ~imem_rsp_valid;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_BOOT;
         pc_q    <= RESET_VECTOR;
         instr_q <= NOP_INSTR;
`ifdef FETCH_MISALIGN_CHECK_EN
         fault_q <= 1'b0;
         stale_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
`ifdef FETCH_MISALIGN_CHECK_EN
         fault_q <= fault_d;
         stale_q <= stale_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      instr_d = instr_q;
      case (state_q)
         S_BOOT: state_d = S_REQ;
         S_REQ: begin
            if (redirect) begin
               pc_d = tgt_pc;
            end else if (imem_req_ready) begin
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (redirect) begin
               pc_d    = tgt_pc;
               state_d = imem_rsp_valid ? S_REQ : S_DROP;
            end else if (imem_rsp_valid) begin
               instr_d = imem_rdata;
               state_d = S_HOLD;
            end
         end
         S_HOLD: begin
            if (redirect) begin
               pc_d    = tgt_pc;
               state_d = hold_stale ? S_DROP : S_REQ;
            end else if (if_ready) begin
               pc_d    = pc_q + 32'd4;
               state_d = hold_stale ? S_DROP : S_REQ;
            end
         end
         S_DROP: begin
            if (redirect) begin
               pc_d = tgt_pc;
            end
            if (imem_rsp_valid) begin
               state_d = S_REQ;
            end
         end
         default: state_d = S_BOOT;
      endcase

`ifdef FETCH_MISALIGN_CHECK_EN
      fault_d = fault_q;
      stale_d = hold_stale;
      if (state_q == S_HOLD && state_d != S_HOLD) begin
         fault_d = 1'b0;
         stale_d = 1'b0;
      end
      if (misalign && state_q != S_BOOT) begin
         pc_d    = redirect_pc;
         state_d = S_HOLD;
         fault_d = 1'b1;
         stale_d = ~imem_rsp_valid &
                   ((state_q == S_WAIT) || (state_q == S_DROP) || (state_q == S_HOLD && stale_q));
      end
`endif
   end

   always_comb begin
      imem_req_valid = 1'b0;
      if_valid       = 1'b0;
      case (state_q)
         S_REQ:   imem_req_valid = ~redirect;
         S_HOLD:  if_valid       = ~redirect;
         default: ;
      endcase
   end

   assign imem_addr  = pc_q;
   assign if_pc      = pc_q;
   assign if_pcplus4 = pc_q + 32'd4;
   assign if_instr   = (if_valid && !fault_q) ? instr_q : NOP_INSTR;
   assign if_fault   = if_valid & fault_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - directed self-checking bench for instr_fetch_unit
module tb_instr_fetch_unit;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk;
   logic        rst_n;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rdata;
   logic        if_valid;
   logic        if_ready;
   logic [31:0] if_instr;
   logic [31:0] if_pc;
   logic [31:0] if_pcplus4;
   logic        if_fault;

   int checks = 0;
   int errors = 0;

   instr_fetch_unit dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .redirect       (redirect),
      .redirect_pc    (redirect_pc),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_addr      (imem_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rdata     (imem_rdata),
      .if_valid       (if_valid),
      .if_ready       (if_ready),
      .if_instr       (if_instr),
      .if_pc          (if_pc),
      .if_pcplus4     (if_pcplus4),
      .if_fault       (if_fault)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n          = 1'b0;
      redirect       = 1'b0;
      redirect_pc    = 32'h0;
      imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b0;
      imem_rdata     = 32'h0;
      if_ready       = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_req_valid", imem_req_valid, 0);
      chk("rst_if_valid", if_valid, 0);
      chk("rst_if_fault", if_fault, 0);
      chk("rst_if_instr", if_instr, NOP);
      chk("rst_if_pc", if_pc, 32'h0);
      chk("rst_if_pcplus4", if_pcplus4, 32'h4);
      chk("rst_imem_addr", imem_addr, 32'h0);

      rst_n = 1'b1;
      #1;
      chk("boot_no_req", imem_req_valid, 0);

      // sequential fetch: 1-cycle memory, decode always ready
      cyc();
      imem_req_ready = 1'b1;
      if_ready       = 1'b1;
      #1;
      chk("seq_req0_valid", imem_req_valid, 1);
      chk("seq_req0_addr", imem_addr, 32'h0);
      cyc();
      imem_rsp_valid = 1'b1;
      imem_rdata     = 32'hAAAA_0000;
      #1;
      chk("seq_wait_no_req", imem_req_valid, 0);
      chk("seq_wait_no_pkt", if_valid, 0);
      cyc();
      imem_rsp_valid = 1'b0;
      #1;
      chk("seq_pkt0_valid", if_valid, 1);
      chk("seq_pkt0_instr", if_instr, 32'hAAAA_0000);
      chk("seq_pkt0_pc", if_pc, 32'h0);
      chk("seq_pkt0_pcplus4", if_pcplus4, 32'h4);
      cyc();
      chk("seq_req1_addr", imem_addr, 32'h4);
      chk("seq_req1_valid", imem_req_valid, 1);
      cyc();
      imem_rsp_valid = 1'b1;
      imem_rdata     = 32'hBBBB_0004;
      cyc();
      imem_rsp_valid = 1'b0;
      if_ready       = 1'b0;
      #1;
      chk("seq_pkt1_pc", if_pc, 32'h4);
      chk("seq_pkt1_pcplus4", if_pcplus4, 32'h8);
      chk("seq_pkt1_instr", if_instr, 32'hBBBB_0004);

      // decode stall: packet must stay put, no new request
      for (int i = 0; i < 5; i++) begin
         cyc();
         chk("stall_if_valid", if_valid, 1);
         chk("stall_if_instr", if_instr, 32'hBBBB_0004);
         chk("stall_if_pc", if_pc, 32'h4);
         chk("stall_no_req", imem_req_valid, 0);
      end
      if_ready = 1'b1;
      cyc();
      chk("seq_req2_addr", imem_addr, 32'h8);
      chk("seq_req2_valid", imem_req_valid, 1);

      // redirect in WAIT, stale response arrives 3 cycles later
      cyc();
      redirect    = 1'b1;
      redirect_pc = 32'h0000_0100;
      #1;
      chk("rdw_no_req", imem_req_valid, 0);
      cyc();
      redirect = 1'b0;
      #1;
      chk("drop_no_pkt", if_valid, 0);
      chk("drop_no_req", imem_req_valid, 0);
      chk("drop_addr", imem_addr, 32'h100);
      cyc();
      cyc();
      imem_rsp_valid = 1'b1;
      imem_rdata     = 32'hDEAD_0008;
      #1;
      chk("drop_stale_hidden_v", if_valid, 0);
      chk("drop_stale_hidden_i", if_instr, NOP);
      cyc();
      imem_rsp_valid = 1'b0;
      #1;
      chk("rdw_req_valid", imem_req_valid, 1);
      chk("rdw_req_addr", imem_addr, 32'h100);
      cyc();
      imem_rsp_valid = 1'b1;
      imem_rdata     = 32'h1111_0100;
      cyc();
      imem_rsp_valid = 1'b0;
      #1;
      chk("rdw_pkt_instr", if_instr, 32'h1111_0100);
      chk("rdw_pkt_pc", if_pc, 32'h100);
      cyc();
      chk("rdw_next_addr", imem_addr, 32'h104);

      // redirect coincident with response in WAIT
      cyc();
      imem_rsp_valid = 1'b1;
      imem_rdata     = 32'hBAD0_0104;
      redirect       = 1'b1;
      redirect_pc    = 32'h0000_0200;
      #1;
      chk("rdrsp_no_pkt", if_valid, 0);
      cyc();
      imem_rsp_valid = 1'b0;
      redirect       = 1'b0;
      #1;
      chk("rdrsp_req_valid", imem_req_valid, 1);
      chk("rdrsp_req_addr", imem_addr, 32'h200);
      chk("rdrsp_no_pkt2", if_valid, 0);
      cyc();
      imem_rsp_valid = 1'b1;
      imem_rdata     = 32'h2222_0200;
      cyc();
      imem_rsp_valid = 1'b0;
      #1;
      chk("rdrsp_pkt_instr", if_instr, 32'h2222_0200);

      // redirect in HOLD beats if_ready, then wrap at top of address space
      redirect    = 1'b1;
      redirect_pc = 32'hFFFF_FFFC;
      #1;
      chk("rdhold_kill_pkt", if_valid, 0);
      cyc();
      redirect = 1'b0;
      #1;
      chk("wrap_req_addr", imem_addr, 32'hFFFF_FFFC);
      chk("wrap_req_valid", imem_req_valid, 1);
      cyc();
      imem_rsp_valid = 1'b1;
      imem_rdata     = 32'h3333_0FFC;
      cyc();
      imem_rsp_valid = 1'b0;
      #1;
      chk("wrap_pkt_pc", if_pc, 32'hFFFF_FFFC);
      chk("wrap_pkt_pcplus4", if_pcplus4, 32'h0);
      cyc();
      chk("wrap_next_addr", imem_addr, 32'h0);
      chk("wrap_next_valid", imem_req_valid, 1);

      // misaligned redirect target
      redirect    = 1'b1;
      redirect_pc = 32'h0000_0102;
      #1;
      chk("mis_no_req", imem_req_valid, 0);
      cyc();
      redirect = 1'b0;
      #1;
`ifdef FETCH_MISALIGN_CHECK_EN
      chk("mis_fault_valid", if_valid, 1);
      chk("mis_fault", if_fault, 1);
      chk("mis_fault_pc", if_pc, 32'h102);
      chk("mis_fault_instr", if_instr, NOP);
      chk("mis_fault_no_req", imem_req_valid, 0);
`else
      chk("mis_aligned_addr", imem_addr, 32'h100);
      chk("mis_req_valid", imem_req_valid, 1);
      chk("mis_no_fault", if_fault, 0);
`endif

      // asynchronous reset mid-operation
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_req_valid", imem_req_valid, 0);
      chk("arst_if_valid", if_valid, 0);
      chk("arst_addr", imem_addr, 32'h0);
      chk("arst_fault", if_fault, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
